// File: rtl/lif_if.sv
// Step/current/threshold bundle into the LIF array and its spike/state outputs.
interface lif_if #(
   parameter int N = 4,
   parameter int W = 8
);
   logic           step_valid;
   logic [N*W-1:0] isyn;
   logic [W-1:0]   thresh;
   logic [N-1:0]   spike;
   logic           spike_any;
   logic [N-1:0]   refractory;
   logic [N*W-1:0] vmem;

   modport master (
      output step_valid, isyn, thresh,
      input  spike, spike_any, refractory, vmem
   );

   modport slave (
      input  step_valid, isyn, thresh,
      output spike, spike_any, refractory, vmem
   );
endinterface

// File: rtl/lif_array.sv
// N independent leaky integrate-and-fire neurons, one time-step per accepted step_valid.
// Spike, vmem and refractory are registered: visible the cycle after the step; no backpressure.
module lif_array #(
   parameter int N          = 4,
   parameter int W          = 8,
   parameter int LEAK_SHIFT = 2,
   parameter int REFRACT    = 3,
   parameter int V_RESET    = 0
) (
   input  logic  clk,
   input  logic  rst_n,
   lif_if.slave  bus
);
   localparam int CW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
   localparam logic [CW-1:0] REFRACT_C = CW'(REFRACT);
   localparam logic [W-1:0]  V_RESET_C = W'(V_RESET);

   logic [W-1:0]  v_q   [N];
   logic [W-1:0]  v_d   [N];
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [W-1:0]  leak  [N];
   logic [W:0]    vn    [N];
   logic [W-1:0]  vsat  [N];
   logic [N-1:0]  spike_q, spike_d;
   logic          spike_any_q, spike_any_d;

   always_comb begin
      spike_d = '0;
      for (int i = 0; i < N; i++) begin
         v_d[i]   = v_q[i];
         cnt_d[i] = cnt_q[i];
         leak[i]  = (LEAK_SHIFT == 0) ? '0 : (v_q[i] >> LEAK_SHIFT);
         // leak <= V, so the W+1 bit sum can only overflow upward
         vn[i]    = {1'b0, v_q[i]} - {1'b0, leak[i]} + {1'b0, bus.isyn[i*W +: W]};
         vsat[i]  = vn[i][W] ? {W{1'b1}} : vn[i][W-1:0];
         if (bus.step_valid) begin
            if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - 1'b1;
               v_d[i]   = V_RESET_C;
            end else if (vsat[i] >= bus.thresh) begin
               spike_d[i] = 1'b1;
               v_d[i]     = V_RESET_C;
               cnt_d[i]   = REFRACT_C;
            end else begin
               v_d[i] = vsat[i];
            end
         end
      end
      spike_any_d = |spike_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            v_q[i]   <= '0;
            cnt_q[i] <= '0;
         end
         spike_q     <= '0;
         spike_any_q <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            v_q[i]   <= v_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         spike_q     <= spike_d;
         spike_any_q <= spike_any_d;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_out
      assign bus.vmem[g*W +: W] = v_q[g];
      assign bus.refractory[g]  = (cnt_q[g] != '0);
   end
   assign bus.spike     = spike_q;
   assign bus.spike_any = spike_any_q;
endmodule

// File: tb/tb_lif_array.sv
// Directed vector table plus model-backed scoreboard for lif_array.
module tb_lif_array;
   localparam int N = 4;
   localparam int W = 8;
   localparam int LS = 2;
   localparam int RF = 3;
   localparam int VR = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lif_if #(.N(N), .W(W)) bus ();
   lif_array #(.N(N), .W(W), .LEAK_SHIFT(LS), .REFRACT(RF), .V_RESET(VR)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   typedef struct {
      logic [N*W-1:0] vmem;
      logic [N-1:0]   spk;
      logic           any;
      logic [N-1:0]   refr;
   } exp_t;

   typedef struct {
      logic       step;
      logic [7:0] is0;
      logic [7:0] thr;
      logic [7:0] ev0;
      logic       es0;
      logic       er0;
   } vec_t;

   exp_t sbq[$];
   int   mv[N];
   int   mc[N];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model_step(input logic stp, input logic [N*W-1:0] is, input int thr);
      exp_t e;
      e.spk = '0;
      for (int i = 0; i < N; i++) begin
         if (stp) begin
            if (mc[i] != 0) begin
               mc[i]--;
               mv[i] = VR;
            end else begin
               int vn;
               vn = mv[i] - ((LS == 0) ? 0 : (mv[i] >> LS)) + int'(is[i*W +: W]);
               if (vn > 255) vn = 255;
               if (vn >= thr) begin
                  e.spk[i] = 1'b1;
                  mv[i] = VR;
                  mc[i] = RF;
               end else begin
                  mv[i] = vn;
               end
            end
         end
         e.vmem[i*W +: W] = mv[i][W-1:0];
         e.refr[i] = (mc[i] != 0);
      end
      e.any = |e.spk;
      return e;
   endfunction

   task automatic cyc(input logic stp, input logic [N*W-1:0] is, input logic [7:0] thr);
      exp_t e;
      @(negedge clk);
      bus.step_valid = stp;
      bus.isyn = is;
      bus.thresh = thr;
      sbq.push_back(model_step(stp, is, int'(thr)));
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sbq.pop_front();
         chk("sb_vmem", bus.vmem, e.vmem);
         chk("sb_spike", {bus.spike_any, bus.spike}, {e.any, e.spk});
         chk("sb_refr", bus.refractory, e.refr);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.step_valid = 1'b1;
      bus.isyn = {N{8'd255}};
      bus.thresh = 8'd0;
      @(posedge clk);
      #1;
      chk("rst_vmem", bus.vmem, '0);
      chk("rst_spike", {bus.spike_any, bus.spike}, '0);
      chk("rst_refr", bus.refractory, '0);
      for (int i = 0; i < N; i++) begin
         mv[i] = 0;
         mc[i] = 0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.step_valid = 1'b0;
   endtask

   vec_t vt[8];
   logic [7:0] thr_r;
   logic [N*W-1:0] is_r;

   initial begin
      bus.step_valid = 1'b0;
      bus.isyn = '0;
      bus.thresh = 8'd100;
      for (int i = 0; i < N; i++) begin
         mv[i] = 0;
         mc[i] = 0;
      end
      do_reset();

      // integrate/fire then refractory on channel 0
      vt[0] = '{1'b1, 8'd40, 8'd100, 8'd40, 1'b0, 1'b0};
      vt[1] = '{1'b1, 8'd40, 8'd100, 8'd70, 1'b0, 1'b0};
      vt[2] = '{1'b1, 8'd40, 8'd100, 8'd93, 1'b0, 1'b0};
      vt[3] = '{1'b1, 8'd40, 8'd100, 8'd0,  1'b1, 1'b1};
      vt[4] = '{1'b1, 8'd40, 8'd100, 8'd0,  1'b0, 1'b1};
      vt[5] = '{1'b1, 8'd40, 8'd100, 8'd0,  1'b0, 1'b1};
      vt[6] = '{1'b1, 8'd40, 8'd100, 8'd0,  1'b0, 1'b0};
      vt[7] = '{1'b1, 8'd40, 8'd100, 8'd40, 1'b0, 1'b0};
      for (int k = 0; k < 8; k++) begin
         cyc(vt[k].step, {24'd0, vt[k].is0}, vt[k].thr);
         chk($sformatf("tbl%0d_v0", k), {24'd0, bus.vmem[7:0]}, {24'd0, vt[k].ev0});
         chk($sformatf("tbl%0d_spk0", k), {31'd0, bus.spike[0]}, {31'd0, vt[k].es0});
         chk($sformatf("tbl%0d_any", k), {31'd0, bus.spike_any}, {31'd0, vt[k].es0});
         chk($sformatf("tbl%0d_ref0", k), {31'd0, bus.refractory[0]}, {31'd0, vt[k].er0});
      end

      // gapped steps on channel 1
      do_reset();
      cyc(1'b1, {16'd0, 8'd40, 8'd0}, 8'd100);
      chk("gap_v1_a", {24'd0, bus.vmem[15:8]}, 32'd40);
      cyc(1'b0, {16'd0, 8'd40, 8'd0}, 8'd100);
      chk("gap_v1_b", {24'd0, bus.vmem[15:8]}, 32'd40);
      chk("gap_idle_spk", {28'd0, bus.spike}, 32'd0);
      cyc(1'b1, {16'd0, 8'd40, 8'd0}, 8'd100);
      chk("gap_v1_c", {24'd0, bus.vmem[15:8]}, 32'd70);
      cyc(1'b0, {16'd0, 8'd40, 8'd0}, 8'd100);
      chk("gap_v1_d", {24'd0, bus.vmem[15:8]}, 32'd70);
      cyc(1'b1, {16'd0, 8'd40, 8'd0}, 8'd100);
      cyc(1'b1, {16'd0, 8'd40, 8'd0}, 8'd100);
      chk("gap_fire", {31'd0, bus.spike[1]}, 32'd1);
      cyc(1'b0, {16'd0, 8'd40, 8'd0}, 8'd100);
      chk("gap_pulse_width", {31'd0, bus.spike[1]}, 32'd0);

      // saturation on channel 2
      do_reset();
      cyc(1'b1, {8'd0, 8'd200, 16'd0}, 8'd255);
      chk("sat_v2", {24'd0, bus.vmem[23:16]}, 32'd200);
      cyc(1'b1, {8'd0, 8'd255, 16'd0}, 8'd255);
      chk("sat_spk255", {31'd0, bus.spike[2]}, 32'd1);
      do_reset();
      cyc(1'b1, {8'd0, 8'd200, 16'd0}, 8'd254);
      cyc(1'b1, {8'd0, 8'd255, 16'd0}, 8'd254);
      chk("sat_spk254", {31'd0, bus.spike[2]}, 32'd1);
      do_reset();
      cyc(1'b1, {8'd0, 8'd200, 16'd0}, 8'd255);
      cyc(1'b1, {8'd0, 8'd0, 16'd0}, 8'd255);
      chk("sat_nospk", {31'd0, bus.spike[2]}, 32'd0);
      chk("sat_v2_leak", {24'd0, bus.vmem[23:16]}, 32'd150);

      // reset while ch0 refractory and ch3 holds 93
      do_reset();
      cyc(1'b1, {8'd40, 16'd0, 8'd60}, 8'd100);
      cyc(1'b1, {8'd40, 16'd0, 8'd60}, 8'd100);
      cyc(1'b1, {8'd40, 16'd0, 8'd60}, 8'd100);
      chk("mid_ref0", {31'd0, bus.refractory[0]}, 32'd1);
      chk("mid_v3", {24'd0, bus.vmem[31:24]}, 32'd93);
      do_reset();
      cyc(1'b1, {24'd0, 8'd40}, 8'd100);
      chk("post_rst_v0", {24'd0, bus.vmem[7:0]}, 32'd40);

      // thresh=0: fire every non-refractory step
      do_reset();
      for (int k = 0; k < 8; k++) begin
         is_r = $urandom;
         cyc(1'b1, is_r, 8'd0);
         chk($sformatf("thr0_spk%0d", k), {28'd0, bus.spike}, (k % 4 == 0) ? 32'hF : 32'h0);
      end

      // random independent channels against the model
      do_reset();
      thr_r = 8'd120;
      for (int k = 0; k < 1000; k++) begin
         if (k % 50 == 0) thr_r = 8'($urandom_range(255, 30));
         is_r = $urandom;
         cyc($urandom_range(3) != 0, is_r, thr_r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
